// File: rtl/abs_sat_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register that
// holds the saturated 7-bit absolute value of the granted sample.
module abs_sat_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [6:0]       out_data,
    output logic             out_id,
    output logic             out_sat,
    input  logic             out_ready,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [6:0]         data_q, data_d;
    logic               id_q, id_d;
    logic               sat_q, sat_d;
    logic               last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_en, gnt_vld, gnt_id, load;
    logic [7:0]         sel;
    logic [6:0]         abs_val;
    logic               abs_sat;

    assign out_valid = (state_q == FULL);
    assign load_en   = !out_valid || out_ready;

    // last_q holds the id granted on the previous load; a tie goes to the other one.
    assign gnt_vld = req0_valid || req1_valid;
    assign gnt_id  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign load    = load_en && gnt_vld && rst_n;

    assign req0_ready = load && !gnt_id;
    assign req1_ready = load && gnt_id;

    assign sel     = gnt_id ? req1_data : req0_data;
    assign abs_sat = (sel == 8'h80);
    always_comb begin
        abs_val = sel[6:0];
        if (abs_sat)
            abs_val = 7'h7F;
        else if (sel[7])
            abs_val = (~sel[6:0]) + 7'd1;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        sat_d   = sat_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: if (load) state_d = FULL;
            FULL:  if (!load && out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (load) begin
            data_d = abs_val;
            id_d   = gnt_id;
            sat_d  = abs_sat;
            last_d = gnt_id;
        end
        if (sat_clr)
            cnt_d = '0;
        else if (load && abs_sat && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= 7'h00;
            id_q    <= 1'b0;
            sat_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            sat_q   <= sat_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data = data_q;
    assign out_id   = id_q;
    assign out_sat  = sat_q;
    assign sat_cnt  = cnt_q;

endmodule

// File: tb/tb_abs_sat_arbiter.sv
// Randomized and directed bench for abs_sat_arbiter against an arithmetic reference model.
module tb_abs_sat_arbiter;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [7:0] req0_data = 0, req1_data = 0;
    logic out_valid, out_id, out_sat, out_ready = 0, sat_clr = 0;
    logic [6:0] out_data;
    logic [CNT_W-1:0] sat_cnt;

    abs_sat_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_sat(out_sat),
        .out_ready(out_ready), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    // Reference model state
    bit m_valid, m_id, m_sat, m_last;
    int m_data, m_cnt;
    bit e_r0, e_r1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int abs_of(input logic [7:0] d, output bit sat);
        int s, a;
        s = $signed(d);
        a = (s < 0) ? -s : s;
        sat = (a > 127);
        return sat ? 127 : a;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_sat = 0; m_data = 0; m_cnt = 0; m_last = 1;
    endtask

    // Inputs are already driven; check pre-edge state, advance one clock, update model.
    task automatic step();
        bit ld, gid, s;
        int a;
        #1;
        ld  = rst_n && (!m_valid || out_ready) && (req0_valid || req1_valid);
        gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
        e_r0 = ld && !gid;
        e_r1 = ld && gid;
        chk("ready0", req0_ready, e_r0);
        chk("ready1", req1_ready, e_r1);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_id", out_id, m_id);
            chk("out_sat", out_sat, m_sat);
        end
        chk("sat_cnt", sat_cnt, m_cnt);
        a = abs_of(gid ? req1_data : req0_data, s);
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (sat_clr) m_cnt = 0;
            else if (ld && s && m_cnt < CMAX) m_cnt++;
            if (ld) begin
                m_valid = 1; m_data = a; m_id = gid; m_sat = s; m_last = gid;
            end else if (out_ready) m_valid = 0;
        end
        @(negedge clk);
    endtask

    logic [7:0] v37 [4] = '{8'h05, 8'hFB, 8'h00, 8'h7F};
    logic [6:0] e37 [4] = '{7'h05, 7'h05, 7'h00, 7'h7F};

    initial begin
        model_reset();
        @(negedge clk);
        step(); step();
        chk("rst_data", out_data, 7'h00);
        rst_n = 1;

        // Single requester, out_ready high
        out_ready = 1; req0_valid = 1;
        foreach (v37[i]) begin
            req0_data = v37[i];
            step();
            #1 chk("t37_data", out_data, e37[i]);
            chk("t37_sat", out_sat, 0);
        end
        req0_valid = 0;

        // Saturation on requester 1
        req1_valid = 1; req1_data = 8'h80; step();
        #1 chk("t38_data0", out_data, 7'h7F); chk("t38_sat0", out_sat, 1); chk("t38_cnt0", sat_cnt, 1);
        req1_data = 8'h81; step();
        #1 chk("t38_data1", out_data, 7'h7F); chk("t38_sat1", out_sat, 0); chk("t38_cnt1", sat_cnt, 1);
        req1_valid = 0; step();

        // Reset, then contention from the first edge
        rst_n = 0; #1 model_reset(); step(); rst_n = 1;
        req0_valid = 1; req1_valid = 1; req0_data = 8'h01; req1_data = 8'h02;
        for (int i = 0; i < 4; i++) begin
            step();
            #1 chk("t39_id", out_id, i % 2);
            chk("t39_valid", out_valid, 1);
        end

        // Backpressure
        req1_valid = 0; req0_data = 8'hF0; step();
        req1_valid = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            #1 chk("t40_data", out_data, 7'h10);
            chk("t40_r0", req0_ready, 0);
            chk("t40_r1", req1_ready, 0);
        end
        out_ready = 1; step(); step();
        req0_valid = 0; req1_valid = 0; step();

        // Counter saturation and clear priority
        sat_clr = 1; step(); sat_clr = 0;
        req0_valid = 1; req0_data = 8'h80;
        for (int i = 0; i < 5; i++) step();
        #1 chk("t41_hold", sat_cnt, 3);
        sat_clr = 1; step(); sat_clr = 0;
        #1 chk("t41_clr", sat_cnt, 0);
        chk("t41_valid", out_valid, 1);

        // Asynchronous reset mid-cycle while FULL
        #2 rst_n = 0;
        #1 chk("t42_valid", out_valid, 0);
        chk("t42_cnt", sat_cnt, 0);
        chk("t42_r0", req0_ready, 0);
        model_reset();
        @(negedge clk); rst_n = 1;
        req0_valid = 1; req1_valid = 1; req0_data = 8'h03; req1_data = 8'h04;
        #1 chk("t42_tie", req0_ready, 1);
        step();

        // Randomized: samples are held stable until accepted
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid || e_r0) begin
                req0_valid = ($urandom_range(3) != 0);
                req0_data  = ($urandom_range(4) == 0) ? 8'h80 : 8'($urandom);
            end
            if (!req1_valid || e_r1) begin
                req1_valid = ($urandom_range(3) != 0);
                req1_data  = ($urandom_range(4) == 0) ? 8'h80 : 8'($urandom);
            end
            out_ready = ($urandom_range(3) != 0);
            sat_clr   = ($urandom_range(15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/abs_sat_arbiter.md
ABS_SAT_ARBITER -- requirements
Module: abs_sat_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of the saturation event counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req0_valid  input  1  requester 0 has a sample.
REQ-005 Port: req0_data  input  8  requester 0 two's-complement sample.
REQ-006 Port: req0_ready  output  1  requester 0 sample accepted this cycle.
REQ-007 Port: req1_valid  input  1  requester 1 has a sample.
REQ-008 Port: req1_data  input  8  requester 1 two's-complement sample.
REQ-009 Port: req1_ready  output  1  requester 1 sample accepted this cycle.
REQ-010 Port: out_valid  output  1  output register holds a result.
REQ-011 Port: out_data  output  7  saturated absolute value.
REQ-012 Port: out_id  output  1  requester that produced out_data.
REQ-013 Port: out_sat  output  1  result was saturated (input 8'h80).
REQ-014 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-015 Port: sat_clr  input  1  synchronous clear of sat_cnt.
REQ-016 Port: sat_cnt  output  CNT_W  count of saturated results loaded.

Function
REQ-017 Transfer rule: a sample transfers when reqN_valid and reqN_ready are both high at a rising edge; a result transfers when out_valid and out_ready are both high.
REQ-018 Define load_en = !out_valid || out_ready; no requester gets ready while load_en is low.
REQ-019 Grant: only one valid -> that requester; both valid -> the requester not granted on the last load (round-robin); neither -> no grant.
REQ-020 reqN_ready is combinational: load_en high, requester N granted; at most one ready high per cycle.
REQ-021 reqN_ready does not depend on the other requester's ready.
REQ-022 Abs rule: bit7=0 -> data[6:0]; bit7=1 and data!=8'h80 -> (~data[6:0])+1 truncated to 7 bits; data==8'h80 -> 7'h7F with out_sat=1.
REQ-023 Latency: a sample accepted at edge k appears on out_data/out_id/out_sat with out_valid=1 after edge k (one cycle).
REQ-024 Output register states: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-025 EMPTY -> FULL on load.
REQ-026 FULL -> EMPTY on result transfer without load.
REQ-027 FULL -> FULL with new contents on simultaneous result transfer and load; back-to-back throughput is one result per cycle.
REQ-028 While FULL and out_ready=0: out_data, out_id and out_sat hold stable, and both readies are low.
REQ-029 The round-robin pointer updates only on a load, to the granted requester id.
REQ-030 sat_cnt increments by 1 on each load with out_sat-to-be=1, and holds at all-ones (no wrap).
REQ-031 sat_clr=1 forces sat_cnt to 0 at the edge and takes priority over a same-cycle increment.
REQ-032 A requester holding valid high with no grant does not lose or reorder its sample; fairness: with both continuously valid, grants alternate 0,1,0,1.

Reset
REQ-033 On rst_n low, immediately and independent of clk:
- out_valid=0, out_data=7'h00, out_id=0, out_sat=0.
- sat_cnt=0.
- Pointer set so requester 0 wins the first tie.
REQ-034 During reset, req0_ready and req1_ready are 0.
REQ-035 Reset mid-operation discards any held result without a transfer.
REQ-036 After rst_n deasserts, the first edge with load_en may accept a sample.

Verification
REQ-037 Single requester, out_ready=1:
- req0 sends 8'h05, 8'hFB, 8'h00, 8'h7F.
- Required out_data 7'h05, 7'h05, 7'h00, 7'h7F, each one cycle after accept, out_id=0, out_sat=0.
REQ-038 Saturation:
- req1 sends 8'h80, then 8'h81.
- Required out_data 7'h7F with out_sat=1 and sat_cnt=1, then 7'h7F with out_sat=0 and sat_cnt still 1.
REQ-039 Contention:
- Both valid continuously after reset, out_ready=1.
- Required out_id sequence 0,1,0,1, one result per cycle.
REQ-040 Backpressure:
- Load 8'hF0, hold out_ready=0 for 3 cycles with both requesters valid.
- Required out_data=7'h10 stable, both readies low, then resume on out_ready=1.
REQ-041 Counter:
- CNT_W=2, send five 8'h80 samples: sat_cnt=3 holds.
- Assert sat_clr together with a sixth 8'h80 load: sat_cnt=0.
REQ-042 Reset while FULL:
- Assert rst_n=0 asynchronously mid-cycle.
- Required out_valid=0 and sat_cnt=0 before the next edge, and requester 0 wins the first tie after release.
